matrix_frame_sender: RTL
========================

MATRIX_FRAME_SENDER -- requirements
Module: matrix_frame_sender

Interface
REQ-001 Parameter: DIM, default 2, matrix dimension byte sent in every header cycle.
REQ-002 Parameter: RES_WAIT, default 5, idle cycles after the trailer before res_mat is sampled (legal range 0..255).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  host offers a matrix pair.
REQ-006 in_ready  output  1  block can accept a pair.
REQ-007 mat_a  input  32  matrix A, row-major, A[0][0] in [31:24], A[1][1] in [7:0].
REQ-008 mat_b  input  32  matrix B, same packing as mat_a.
REQ-009 ctrl_logic  output  2  loader control code: 1 = header, 0 = data, 2 = end/hold.
REQ-010 data_send  output  8  loader data byte.
REQ-011 res_mat  input  64  loader result: C00 [63:48], C01 [47:32], C10 [31:16], C11 [15:0].
REQ-012 res_valid  output  1  res_out holds a captured result.
REQ-013 res_ready  input  1  host consumes the result.
REQ-014 res_out  output  64  captured result, same packing as res_mat.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, LOAD, TRAIL, WAIT, RESP, plus one cycle counter of at least 8 bits.
REQ-017 ctrl_logic, data_send, res_valid and res_out SHALL be registered outputs.
REQ-018 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-019 On acceptance, the block SHALL latch mat_a and mat_b; later changes to those inputs SHALL NOT affect the frame.
REQ-020 On the acceptance edge the FSM SHALL enter HDR, so the first header cycle is visible in the next clock period (zero bubble).
REQ-021 HDR: 4 cycles, ctrl_logic=1, data_send=DIM.
REQ-022 LOAD: 8 cycles, ctrl_logic=0; data_send in order is A[31:24], A[23:16], A[15:8], A[7:0], B[31:24], B[23:16], B[15:8], B[7:0].
REQ-023 TRAIL: 2 cycles, ctrl_logic=2, data_send=0; every frame is exactly 14 cycles.
REQ-024 WAIT: RES_WAIT cycles, ctrl_logic=2, data_send=0; when RES_WAIT=0, WAIT is skipped.
REQ-025 At the last WAIT edge (or the last TRAIL edge when RES_WAIT=0), res_out SHALL load res_mat, res_valid SHALL go to 1, and the FSM SHALL enter RESP.
REQ-026 RESP: res_valid and res_out held stable until res_valid & res_ready at an edge; on that edge res_valid goes to 0 and the FSM enters IDLE.
REQ-027 res_out SHALL retain its last value after consumption and only be overwritten by the next capture.
REQ-028 IDLE, WAIT and RESP SHALL drive ctrl_logic=2, data_send=0.
REQ-029 in_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-030 res_ready while res_valid=0 SHALL have no effect.
REQ-031 In RESP, acceptance is not possible in the same cycle as the result handshake; in_ready rises the cycle after consumption.
REQ-032 No arithmetic SHALL be performed on matrix data; bytes pass through unmodified.

Reset
REQ-033 While rst_n=0: FSM=IDLE, counter=0, ctrl_logic=2, data_send=0, res_valid=0, res_out=0, busy=0, in_ready=0.
REQ-034 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-035 Reset asserted mid-frame or mid-RESP SHALL abort immediately (asynchronously) to the REQ-033 values; the pending result is discarded.

Verification
REQ-036 Basic frame: DIM=2, mat_a=32'h01020304, mat_b=32'h05060708 accepted -> ctrl/data = 4x(1,02), then (0,01)(0,02)(0,03)(0,04)(0,05)(0,06)(0,07)(0,08), then 2x(2,00).
REQ-037 Result capture: res_mat=64'h0013_0016_002B_0032 present, RES_WAIT=5 -> res_valid rises 7 cycles after the last data byte, res_out=64'h0013_0016_002B_0032.
REQ-038 Backpressure: res_ready held 0 for 10 cycles -> res_valid and res_out stable, in_ready=0, busy=1; res_ready=1 -> res_valid=0 next cycle and in_ready=1.
REQ-039 Ignored request: in_valid pulsed with new data during LOAD -> current byte stream unchanged and no second frame starts.
REQ-040 Reset mid-LOAD: rst_n=0 at the 3rd data byte -> immediately ctrl_logic=2, data_send=0, busy=0; after release, a fresh frame with new data is sent correctly.
REQ-041 Back-to-back: three pairs offered continuously with res_ready=1 and RES_WAIT=0 -> three 14-cycle frames, each separated by exactly 2 non-frame cycles (RESP, IDLE).

Source files
------------

// File: rtl/matrix_frame_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_sender_if
// Brief    : Host/loader handshake and data bundle for matrix_frame_sender.
// Revision : 1.0
// ============================================================================
interface matrix_frame_sender_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mat_a;
  logic [31:0] mat_b;
  logic [1:0]  ctrl_logic;
  logic [7:0]  data_send;
  logic [63:0] res_mat;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_out;
  logic        busy;

  modport slave (
    input  in_valid, mat_a, mat_b, res_mat, res_ready,
    output in_ready, ctrl_logic, data_send, res_valid, res_out, busy
  );

  modport master (
    output in_valid, mat_a, mat_b, res_mat, res_ready,
    input  in_ready, ctrl_logic, data_send, res_valid, res_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/matrix_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_sender
// Brief    : Streams a header/data/trailer frame for a 2x2 matrix pair to the
//            loader, then captures and holds the loader's result for the host.
// Revision : 1.0
// ============================================================================
module matrix_frame_sender #(
  parameter int DIM      = 2,
  parameter int RES_WAIT = 5
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  matrix_frame_sender_if.slave   bus
);

  localparam logic [7:0] C_DIM       = 8'(DIM);
  localparam logic [7:0] C_WAIT_LAST = 8'(RES_WAIT - 1);
  localparam logic [1:0] C_CTRL_DATA = 2'd0;
  localparam logic [1:0] C_CTRL_HDR  = 2'd1;
  localparam logic [1:0] C_CTRL_END  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_TRAIL = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [31:0] r_mat_a;
  logic [31:0] r_mat_b;
  logic        r_in_ready;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_data;
  logic        r_res_valid;
  logic [63:0] r_res_out;
  logic        w_accept;
  logic        w_capture;
  logic        w_consume;
  logic [1:0]  w_ctrl_next;
  logic [7:0]  w_data_next;
  logic [2:0]  w_byte_idx;
  logic [5:0]  w_shift;
  logic [63:0] w_frame;

  assign w_accept  = (r_state == S_IDLE) && bus.in_valid && r_in_ready;
  assign w_consume = (r_state == S_RESP) && r_res_valid && bus.res_ready;

  // Byte 0 of the load phase is A[31:24], i.e. the top byte of {A,B}.
  assign w_frame    = {r_mat_a, r_mat_b};
  assign w_byte_idx = w_cnt_next[2:0];
  assign w_shift    = {~w_byte_idx, 3'b000};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_next = S_HDR;
        w_cnt_next   = 8'd0;
      end
      S_HDR: if (r_cnt == 8'd3) begin
        w_state_next = S_LOAD;
        w_cnt_next   = 8'd0;
      end else w_cnt_next = r_cnt + 8'd1;
      S_LOAD: if (r_cnt == 8'd7) begin
        w_state_next = S_TRAIL;
        w_cnt_next   = 8'd0;
      end else w_cnt_next = r_cnt + 8'd1;
      S_TRAIL: if (r_cnt == 8'd1) begin
        w_cnt_next = 8'd0;
        if (RES_WAIT == 0) begin
          w_state_next = S_RESP;
          w_capture    = 1'b1;
        end else w_state_next = S_WAIT;
      end else w_cnt_next = r_cnt + 8'd1;
      S_WAIT: if (r_cnt == C_WAIT_LAST) begin
        w_state_next = S_RESP;
        w_cnt_next   = 8'd0;
        w_capture    = 1'b1;
      end else w_cnt_next = r_cnt + 8'd1;
      S_RESP: if (w_consume) w_state_next = S_IDLE;
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_ctrl_next = C_CTRL_END;
    w_data_next = 8'd0;
    case (w_state_next)
      S_HDR: begin
        w_ctrl_next = C_CTRL_HDR;
        w_data_next = C_DIM;
      end
      S_LOAD: begin
        w_ctrl_next = C_CTRL_DATA;
        w_data_next = w_frame[w_shift +: 8];
      end
      default: begin
        w_ctrl_next = C_CTRL_END;
        w_data_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_mat_a     <= 32'd0;
      r_mat_b     <= 32'd0;
      r_in_ready  <= 1'b0;
      r_ctrl      <= C_CTRL_END;
      r_data      <= 8'd0;
      r_res_valid <= 1'b0;
      r_res_out   <= 64'd0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_state_next == S_IDLE);
      r_ctrl     <= w_ctrl_next;
      r_data     <= w_data_next;
      if (w_accept) begin
        r_mat_a <= bus.mat_a;
        r_mat_b <= bus.mat_b;
      end
      if (w_capture) begin
        r_res_out   <= bus.res_mat;
        r_res_valid <= 1'b1;
      end else if (w_consume) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.ctrl_logic = r_ctrl;
  assign bus.data_send  = r_data;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_out    = r_res_out;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
